// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file debug controller.
package regfile_pkg;

   localparam int unsigned VAL_SIZE_DEF = 64;
   localparam int unsigned REG_ADDR_DEF = 4;

   localparam logic [3:0] IRAX  = 4'h0;
   localparam logic [3:0] IRCX  = 4'h1;
   localparam logic [3:0] IRDX  = 4'h2;
   localparam logic [3:0] IRBX  = 4'h3;
   localparam logic [3:0] IRSP  = 4'h4;
   localparam logic [3:0] IRBP  = 4'h5;
   localparam logic [3:0] IRSI  = 4'h6;
   localparam logic [3:0] IRDI  = 4'h7;
   localparam logic [3:0] IR8   = 4'h8;
   localparam logic [3:0] IR9   = 4'h9;
   localparam logic [3:0] IR10  = 4'ha;
   localparam logic [3:0] IR11  = 4'hb;
   localparam logic [3:0] IR12  = 4'hc;
   localparam logic [3:0] IR13  = 4'hd;
   localparam logic [3:0] IR14  = 4'he;
   localparam logic [3:0] RNONE = 4'hf;

   typedef enum logic [2:0] {
      StRun,
      StDrain,
      StHalted,
      StDbgRd,
      StDbgWr
   } dbgState_e;

endpackage

// File: rtl/regfile_port_mux.sv
// Steers register-file ports between pipeline traffic and the latched debug access.
module regfile_port_mux
   import regfile_pkg::*;
#(
   parameter int unsigned VAL_SIZE = VAL_SIZE_DEF,
   parameter int unsigned REG_ADDR = REG_ADDR_DEF
) (
   input  dbgState_e            state,
   input  logic [REG_ADDR-1:0]  dbgAddr,
   input  logic [VAL_SIZE-1:0]  dbgWdata,
   input  logic                 wrBlock,
   input  logic [REG_ADDR-1:0]  p_srcA,
   input  logic [REG_ADDR-1:0]  p_srcB,
   input  logic [REG_ADDR-1:0]  p_dstE,
   input  logic [REG_ADDR-1:0]  p_dstM,
   input  logic [VAL_SIZE-1:0]  p_valE,
   input  logic [VAL_SIZE-1:0]  p_valM,
   input  logic [VAL_SIZE-1:0]  rf_valA,
   input  logic [VAL_SIZE-1:0]  rf_valB,
   output logic [REG_ADDR-1:0]  rf_srcA,
   output logic [REG_ADDR-1:0]  rf_srcB,
   output logic [REG_ADDR-1:0]  rf_dstE,
   output logic [REG_ADDR-1:0]  rf_dstM,
   output logic [VAL_SIZE-1:0]  rf_valE,
   output logic [VAL_SIZE-1:0]  rf_valM,
   output logic [VAL_SIZE-1:0]  p_valA,
   output logic [VAL_SIZE-1:0]  p_valB
);

   localparam logic [REG_ADDR-1:0] NoReg = REG_ADDR'(RNONE);

   always_comb begin
      rf_srcA = p_srcA;
      rf_srcB = p_srcB;
      rf_dstE = p_dstE;
      rf_dstM = p_dstM;
      rf_valE = p_valE;
      rf_valM = p_valM;
      p_valA  = rf_valA;
      p_valB  = rf_valB;
      unique case (state)
         StRun, StDrain: ;
         StHalted: begin
            rf_dstE = NoReg;
            rf_dstM = NoReg;
            p_valA  = '0;
            p_valB  = '0;
         end
         StDbgWr: begin
            rf_dstE = wrBlock ? NoReg : dbgAddr;
            rf_valE = dbgWdata;
            rf_dstM = NoReg;
            p_valA  = '0;
            p_valB  = '0;
         end
         StDbgRd: begin
            rf_srcA = dbgAddr;
            rf_dstE = NoReg;
            rf_dstM = NoReg;
            p_valA  = '0;
            p_valB  = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/regfile_dbg_ctrl.sv
// Debug halt/access controller in front of the Y86-64 register file.
// Optional REGFILE_DBG_PROTECT_EN rejects debug writes to %rsp.
module regfile_dbg_ctrl
   import regfile_pkg::*;
#(
   parameter int unsigned VAL_SIZE     = VAL_SIZE_DEF,
   parameter int unsigned REG_ADDR     = REG_ADDR_DEF,
   parameter int unsigned DRAIN_CYCLES = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [REG_ADDR-1:0]  p_srcA,
   input  logic [REG_ADDR-1:0]  p_srcB,
   input  logic [REG_ADDR-1:0]  p_dstE,
   input  logic [REG_ADDR-1:0]  p_dstM,
   input  logic [VAL_SIZE-1:0]  p_valE,
   input  logic [VAL_SIZE-1:0]  p_valM,
   output logic [VAL_SIZE-1:0]  p_valA,
   output logic [VAL_SIZE-1:0]  p_valB,
   output logic                 p_stall,
   output logic [REG_ADDR-1:0]  rf_srcA,
   output logic [REG_ADDR-1:0]  rf_srcB,
   output logic [REG_ADDR-1:0]  rf_dstE,
   output logic [REG_ADDR-1:0]  rf_dstM,
   output logic [VAL_SIZE-1:0]  rf_valE,
   output logic [VAL_SIZE-1:0]  rf_valM,
   input  logic [VAL_SIZE-1:0]  rf_valA,
   input  logic [VAL_SIZE-1:0]  rf_valB,
   input  logic                 dbg_halt_req,
   output logic                 dbg_halted,
   input  logic                 dbg_req_valid,
   output logic                 dbg_req_ready,
   input  logic                 dbg_we,
   input  logic [REG_ADDR-1:0]  dbg_addr,
   input  logic [VAL_SIZE-1:0]  dbg_wdata,
   output logic                 dbg_rsp_valid,
   output logic [VAL_SIZE-1:0]  dbg_rdata,
   output logic                 dbg_rsp_err
);

   dbgState_e           stateQ, stateD;
   logic [3:0]          cntQ, cntD;
   logic [REG_ADDR-1:0] addrQ;
   logic [VAL_SIZE-1:0] wdataQ;
   logic [VAL_SIZE-1:0] rdataQ;
   logic                rspValidQ;
   logic                accept;
   logic                wrBlock;

   assign dbg_req_ready = (stateQ == StHalted);
   assign accept        = dbg_req_valid && dbg_req_ready;
   assign p_stall       = (stateQ != StRun);
   // Debug owns the register file for the whole halted period, including accesses.
   assign dbg_halted    = (stateQ == StHalted) || (stateQ == StDbgRd) || (stateQ == StDbgWr);
   assign dbg_rsp_valid = rspValidQ;
   assign dbg_rdata     = rdataQ;

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StRun: begin
            if (dbg_halt_req) begin
               stateD = StDrain;
               cntD   = 4'(DRAIN_CYCLES - 1);
            end
         end
         StDrain: begin
            if (cntQ == 4'd0) stateD = StHalted;
            else              cntD   = cntQ - 4'd1;
         end
         StHalted: begin
            if (accept)             stateD = dbg_we ? StDbgWr : StDbgRd;
            else if (!dbg_halt_req) stateD = StRun;
         end
         StDbgRd, StDbgWr: stateD = StHalted;
         default:          stateD = StRun;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ    <= StRun;
         cntQ      <= 4'd0;
         addrQ     <= '0;
         wdataQ    <= '0;
         rdataQ    <= '0;
         rspValidQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         rspValidQ <= (stateQ == StDbgRd) || (stateQ == StDbgWr);
         if (accept) begin
            addrQ  <= dbg_addr;
            wdataQ <= dbg_wdata;
         end
         if (stateQ == StDbgRd) begin
            rdataQ <= (addrQ == REG_ADDR'(RNONE)) ? '0 : rf_valA;
         end
      end
   end

`ifdef REGFILE_DBG_PROTECT_EN
   logic rspErrQ;

   assign wrBlock = (addrQ == REG_ADDR'(IRSP));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rspErrQ <= 1'b0;
      else        rspErrQ <= (stateQ == StDbgWr) && wrBlock;
   end

   assign dbg_rsp_err = rspErrQ;
`else
   assign wrBlock     = 1'b0;
   assign dbg_rsp_err = 1'b0;
`endif

   regfile_port_mux #(
      .VAL_SIZE (VAL_SIZE),
      .REG_ADDR (REG_ADDR)
   ) u_port_mux (
      .state    (stateQ),
      .dbgAddr  (addrQ),
      .dbgWdata (wdataQ),
      .wrBlock  (wrBlock),
      .p_srcA   (p_srcA),
      .p_srcB   (p_srcB),
      .p_dstE   (p_dstE),
      .p_dstM   (p_dstM),
      .p_valE   (p_valE),
      .p_valM   (p_valM),
      .rf_valA  (rf_valA),
      .rf_valB  (rf_valB),
      .rf_srcA  (rf_srcA),
      .rf_srcB  (rf_srcB),
      .rf_dstE  (rf_dstE),
      .rf_dstM  (rf_dstM),
      .rf_valE  (rf_valE),
      .rf_valM  (rf_valM),
      .p_valA   (p_valA),
      .p_valB   (p_valB)
   );

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Bench for regfile_dbg_ctrl: register-file model, passthrough/debug vector tables,
// response scoreboard, and hand sequences for drain, resume race and reset.
module tb_regfile_dbg_ctrl;

   localparam int unsigned DRAIN = 5;

`ifdef REGFILE_DBG_PROTECT_EN
   localparam logic        SP_ERR = 1'b1;
   localparam logic [63:0] SP_VAL = 64'h8;
`else
   localparam logic        SP_ERR = 1'b0;
   localparam logic [63:0] SP_VAL = 64'h10;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  p_srcA, p_srcB, p_dstE, p_dstM;
   logic [63:0] p_valE, p_valM, p_valA, p_valB;
   logic        p_stall;
   logic [3:0]  rf_srcA, rf_srcB, rf_dstE, rf_dstM;
   logic [63:0] rf_valE, rf_valM, rf_valA, rf_valB;
   logic        dbg_halt_req, dbg_halted, dbg_req_valid, dbg_req_ready, dbg_we;
   logic [3:0]  dbg_addr;
   logic [63:0] dbg_wdata, dbg_rdata;
   logic        dbg_rsp_valid, dbg_rsp_err;

   int checks   = 0;
   int failures = 0;
   int cycleCnt = 0;
   int rspSeen  = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   regfile_dbg_ctrl #(
      .VAL_SIZE     (64),
      .REG_ADDR     (4),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .p_srcA        (p_srcA),
      .p_srcB        (p_srcB),
      .p_dstE        (p_dstE),
      .p_dstM        (p_dstM),
      .p_valE        (p_valE),
      .p_valM        (p_valM),
      .p_valA        (p_valA),
      .p_valB        (p_valB),
      .p_stall       (p_stall),
      .rf_srcA       (rf_srcA),
      .rf_srcB       (rf_srcB),
      .rf_dstE       (rf_dstE),
      .rf_dstM       (rf_dstM),
      .rf_valE       (rf_valE),
      .rf_valM       (rf_valM),
      .rf_valA       (rf_valA),
      .rf_valB       (rf_valB),
      .dbg_halt_req  (dbg_halt_req),
      .dbg_halted    (dbg_halted),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_ready (dbg_req_ready),
      .dbg_we        (dbg_we),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rdata     (dbg_rdata),
      .dbg_rsp_err   (dbg_rsp_err)
   );

   // External 15-entry register file; id 4'hf reads 0 and ignores writes.
   logic [63:0] regs [0:14];
   logic        rfLoad;

   assign rf_valA = (rf_srcA == 4'hf) ? 64'h0 : regs[rf_srcA];
   assign rf_valB = (rf_srcB == 4'hf) ? 64'h0 : regs[rf_srcB];

   always @(posedge clock) begin
      if (rfLoad) begin
         for (int i = 0; i < 15; i++) regs[i] <= 64'(2 * i);
      end else begin
         if (rf_dstE != 4'hf) regs[rf_dstE] <= rf_valE;
         if (rf_dstM != 4'hf) regs[rf_dstM] <= rf_valM;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Scoreboard of outstanding debug responses.
   typedef struct {
      logic        isRead;
      logic [63:0] rdata;
      logic        err;
      int          cycle;
   } sbEntry_t;

   sbEntry_t sb [$];

   always @(negedge clock) begin
      if (reset) begin
         if (dbg_rsp_valid) begin
            rspSeen++;
            if (sb.size() == 0) begin
               check("unexpected_rsp", 64'(dbg_rsp_valid), 64'h0);
            end else begin
               sbEntry_t e;
               e = sb.pop_front();
               check("rsp_cycle", 64'(cycleCnt), 64'(e.cycle));
               check("rsp_err", 64'(dbg_rsp_err), 64'(e.err));
               if (e.isRead) check("rsp_rdata", dbg_rdata, e.rdata);
            end
         end else if (sb.size() > 0 && cycleCnt > sb[0].cycle) begin
            check("rsp_missing", 64'(dbg_rsp_valid), 64'h1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic dbgAccess(input logic we, input logic [3:0] addr, input logic [63:0] wdata,
                            input logic [63:0] expR, input logic expE);
      int w = 0;
      sbEntry_t e;
      dbg_req_valid = 1'b1;
      dbg_we        = we;
      dbg_addr      = addr;
      dbg_wdata     = wdata;
      while (!dbg_req_ready && w < 20) begin
         @(posedge clock); #1;
         w++;
      end
      if (!dbg_req_ready) begin
         check("req_ready_timeout", 64'(dbg_req_ready), 64'h1);
         dbg_req_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      e.isRead = !we;
      e.rdata  = expR;
      e.err    = expE;
      e.cycle  = cycleCnt + 1;
      sb.push_back(e);
      dbg_req_valid = 1'b0;
   endtask

   task automatic drainSb();
      int w = 0;
      while (sb.size() != 0 && w < 10) begin
         @(posedge clock); #1;
         w++;
      end
      check("sb_empty", 64'(sb.size()), 64'h0);
   endtask

   typedef struct {
      logic [3:0]  srcA, srcB, dstE;
      logic [63:0] valE, expA, expB;
   } pVec_t;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [63:0] wdata, expR;
      logic        expE;
   } dVec_t;

   pVec_t pv [4];
   dVec_t dv [9];

   initial begin
      int lat;
      int rspBase;

      pv[0] = '{srcA: 4'h1, srcB: 4'h3, dstE: 4'hf, valE: 64'h0,  expA: 64'h2,  expB: 64'h6};
      pv[1] = '{srcA: 4'h5, srcB: 4'hf, dstE: 4'h5, valE: 64'h55, expA: 64'ha,  expB: 64'h0};
      pv[2] = '{srcA: 4'h5, srcB: 4'h0, dstE: 4'hf, valE: 64'h0,  expA: 64'h55, expB: 64'h0};
      pv[3] = '{srcA: 4'he, srcB: 4'h7, dstE: 4'hf, valE: 64'h0,  expA: 64'h1c, expB: 64'he};

      dv[0] = '{we: 1'b1, addr: 4'h3, wdata: 64'hDEAD_BEEF, expR: 64'h0,         expE: 1'b0};
      dv[1] = '{we: 1'b0, addr: 4'h3, wdata: 64'h0,         expR: 64'hDEAD_BEEF, expE: 1'b0};
      dv[2] = '{we: 1'b1, addr: 4'hf, wdata: 64'h1,         expR: 64'h0,         expE: 1'b0};
      dv[3] = '{we: 1'b0, addr: 4'hf, wdata: 64'h0,         expR: 64'h0,         expE: 1'b0};
      dv[4] = '{we: 1'b1, addr: 4'h4, wdata: 64'h10,        expR: 64'h0,         expE: SP_ERR};
      dv[5] = '{we: 1'b0, addr: 4'h4, wdata: 64'h0,         expR: SP_VAL,        expE: 1'b0};
      dv[6] = '{we: 1'b0, addr: 4'h2, wdata: 64'h0,         expR: 64'h104,       expE: 1'b0};
      dv[7] = '{we: 1'b1, addr: 4'h7, wdata: 64'h77,        expR: 64'h0,         expE: 1'b0};
      dv[8] = '{we: 1'b0, addr: 4'h7, wdata: 64'h0,         expR: 64'h77,        expE: 1'b0};

      reset = 1'b0; rfLoad = 1'b1;
      p_srcA = 4'hf; p_srcB = 4'hf; p_dstE = 4'hf; p_dstM = 4'hf; p_valE = '0; p_valM = '0;
      dbg_halt_req = 1'b0; dbg_req_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_p_stall", 64'(p_stall), 64'h0);
      check("rst_halted", 64'(dbg_halted), 64'h0);
      check("rst_rsp_valid", 64'(dbg_rsp_valid), 64'h0);
      check("rst_rsp_err", 64'(dbg_rsp_err), 64'h0);
      check("rst_rdata", dbg_rdata, 64'h0);
      check("rst_ready", 64'(dbg_req_ready), 64'h0);
      rfLoad = 1'b0;
      reset  = 1'b1;

      // Passthrough in RUN
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         p_srcA = pv[i].srcA; p_srcB = pv[i].srcB; p_dstE = pv[i].dstE; p_valE = pv[i].valE;
         #1;
         check("run_p_valA", p_valA, pv[i].expA);
         check("run_p_valB", p_valB, pv[i].expB);
         check("run_rf_dstE", 64'(rf_dstE), 64'(pv[i].dstE));
         check("run_rf_valE", rf_valE, pv[i].valE);
         check("run_p_stall", 64'(p_stall), 64'h0);
      end

      // Halt with %rdx write-backs still in flight
      @(posedge clock); #1;
      p_dstE = 4'h2; p_valE = 64'h100; p_srcA = 4'h1;
      dbg_halt_req = 1'b1;
      @(posedge clock); #1;
      check("drain_p_stall", 64'(p_stall), 64'h1);
      lat = 0;
      while (!dbg_halted && lat < 20) begin
         check("drain_rf_dstE", 64'(rf_dstE), 64'h2);
         p_valE = 64'h100 + 64'(lat);
         @(posedge clock); #1;
         lat++;
      end
      check("halt_latency", 64'(lat), 64'(DRAIN));
      check("halted_rf_dstE", 64'(rf_dstE), 64'hf);
      check("halted_p_valA", p_valA, 64'h0);
      check("halted_ready", 64'(dbg_req_ready), 64'h1);
      p_dstE = 4'hf;

      for (int i = 0; i < 9; i++) dbgAccess(dv[i].we, dv[i].addr, dv[i].wdata, dv[i].expR, dv[i].expE);
      drainSb();

      // Resume request drops in the same cycle as an accepted read
      @(posedge clock); #1;
      check("pre_race_ready", 64'(dbg_req_ready), 64'h1);
      dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h3; dbg_halt_req = 1'b0;
      begin
         sbEntry_t e;
         @(posedge clock); #1;
         e.isRead = 1'b1; e.rdata = 64'hDEAD_BEEF; e.err = 1'b0; e.cycle = cycleCnt + 1;
         sb.push_back(e);
      end
      dbg_req_valid = 1'b0;
      check("race_rd_stall", 64'(p_stall), 64'h1);
      @(posedge clock); #1;
      check("race_halted", 64'(dbg_halted), 64'h1);
      @(posedge clock); #1;
      check("resume_p_stall", 64'(p_stall), 64'h0);
      check("resume_halted", 64'(dbg_halted), 64'h0);
      check("resume_ready", 64'(dbg_req_ready), 64'h0);
      drainSb();

      // Reset in the middle of a debug read
      dbg_halt_req = 1'b1;
      lat = 0;
      while (!dbg_halted && lat < 30) begin
         @(posedge clock); #1;
         lat++;
      end
      check("rehalt", 64'(dbg_halted), 64'h1);
      dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h3;
      @(posedge clock); #1;
      dbg_req_valid = 1'b0;
      check("rst_mid_in_rd", 64'(dbg_req_ready), 64'h0);
      rspBase = rspSeen;
      #2;
      reset = 1'b0;
      dbg_halt_req = 1'b0;
      #1;
      check("midrst_p_stall", 64'(p_stall), 64'h0);
      check("midrst_halted", 64'(dbg_halted), 64'h0);
      check("midrst_rdata", dbg_rdata, 64'h0);
      check("midrst_rsp_valid", 64'(dbg_rsp_valid), 64'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check("midrst_no_rsp", 64'(rspSeen - rspBase), 64'h0);
      check("midrst_run", 64'(p_stall), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
